// File: rtl/mem_port_arbiter_if.sv
// Bus bundle of mem_port_arbiter: fetch port, data port, memory macro side and busy flag.
// The arbiter connects through the slave modport and its environment through master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_kill;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  arb_busy;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output arb_busy
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  arb_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and data access,
// one transaction in flight. Optional wait-cycle counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_wait,
    output logic [31:0]         perf_d_wait
`endif
);

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] starve_q, starve_d;
    owner_e     owner_q, owner_d;
    logic       killed_q, killed_d;
    logic       store_q, store_d;

    logic              eligible, fetch_wins, if_gnt, d_gnt, issue, resp;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] zero_data;

    // Outputs are forced low while reset is held so that every output reads 0 in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        zero_data  = '0;
        eligible   = !reset && (cnt_q <= 4'd1);
        fetch_wins = bus.if_req && (!bus.d_req || (starve_q == SMAX));
        if_gnt     = eligible && fetch_wins;
        d_gnt      = eligible && bus.d_req && !fetch_wins;
        issue      = if_gnt || d_gnt;
        resp       = !reset && (cnt_q == 4'd1);
        issue_addr = '0;
        if (d_gnt) begin
            issue_addr = bus.d_addr;
        end else if (if_gnt) begin
            issue_addr = bus.if_addr;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = d_gnt && bus.d_we;
    assign bus.mem_addr  = issue_addr;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : zero_data;
    assign bus.mem_wstrb = d_gnt ? bus.d_wstrb : '0;
    assign bus.arb_busy  = !reset && (cnt_q != 4'd0);

    assign bus.d_rvalid  = resp && (owner_q == OWN_DATA);
    assign bus.d_rdata   = (bus.d_rvalid && !store_q) ? bus.mem_rdata : zero_data;
    // A kill arriving in the response cycle itself still suppresses the response.
    assign bus.if_rvalid = resp && (owner_q == OWN_FETCH) && !killed_q && !bus.if_kill;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : zero_data;

    always_comb begin
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        killed_d = killed_q;
        store_d  = store_q;
        starve_d = starve_q;
        if (issue) begin
            cnt_d    = LAT;
            owner_d  = d_gnt ? OWN_DATA : OWN_FETCH;
            store_d  = d_gnt && bus.d_we;
            killed_d = if_gnt && bus.if_kill;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (owner_q == OWN_FETCH && bus.if_kill) begin
                killed_d = 1'b1;
            end
        end
        if (!bus.if_req || if_gnt) begin
            starve_d = 4'd0;
        end else if (d_gnt && (starve_q != SMAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            cnt_q    <= 4'd0;
            starve_q <= 4'd0;
            owner_q  <= OWN_FETCH;
            killed_q <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            killed_q <= killed_d;
            store_q  <= store_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;

    always_comb begin
        perf_if_d = perf_if_q;
        perf_d_d  = perf_d_q;
        if (bus.if_req && !if_gnt && (perf_if_q != 32'hFFFF_FFFF)) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (bus.d_req && !d_gnt && (perf_d_q != 32'hFFFF_FFFF)) begin
            perf_d_d = perf_d_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q <= 32'd0;
            perf_d_q  <= 32'd0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_d_wait  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a deadline-based transaction model and a behavioural RAM.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait, perf_d_wait;
`endif

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_wait(perf_if_wait),
        .perf_d_wait (perf_d_wait)
`endif
    );

    typedef struct {
        logic        if_gnt, d_gnt, mem_en, mem_we;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_addr, mem_wdata;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        arb_busy;
        bit          chk_addr, chk_wdata, chk_wstrb;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // Model: at most one pending transaction, answered exactly MEM_LAT cycles after issue.
    bit          p_valid;
    int          p_due;
    bit          p_fetch, p_store, p_killed;
    logic [31:0] p_data;
    int          starve;
    bit          last_ig, last_dg;
    longint      m_pi, m_pd;
    logic [31:0] mdl_mem [int];

    // Behavioural RAM driven by the DUT's memory-side bus.
    logic [31:0] ram [int];
    rd_t         rdq [$];
    exp_t        obs;

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(logic [31:0] a);
        int w = int'(a >> 2);
        return mdl_mem.exists(w) ? mdl_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ram_rd(logic [31:0] a);
        int w = int'(a >> 2);
        return ram.exists(w) ? ram[w] : init_word(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_asserts++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic model_eval(output exp_t e);
        bit resp, free, fetch_wins;
        e = '{default: '0};
        if (reset) return;
        resp       = p_valid && (cyc == p_due);
        free       = !p_valid || resp;
        fetch_wins = bus.if_req && (!bus.d_req || starve == STARVE_MAX);
        e.if_gnt   = free && fetch_wins;
        e.d_gnt    = free && bus.d_req && !fetch_wins;
        e.mem_en   = e.if_gnt || e.d_gnt;
        e.mem_we   = e.d_gnt && bus.d_we;
        e.arb_busy = p_valid;
        e.chk_addr = e.mem_en;
        e.mem_addr = e.d_gnt ? bus.d_addr : bus.if_addr;
        e.chk_wdata = e.mem_we;
        e.mem_wdata = bus.d_wdata;
        e.chk_wstrb = !(e.d_gnt && !bus.d_we);
        e.mem_wstrb = e.mem_we ? bus.d_wstrb : 4'b0000;
        if (resp && p_fetch && !p_killed && !bus.if_kill) begin
            e.if_rvalid = 1'b1;
            e.if_rdata  = p_data;
        end
        if (resp && !p_fetch) begin
            e.d_rvalid = 1'b1;
            e.d_rdata  = p_store ? 32'h0 : p_data;
        end
    endtask

    task automatic model_commit(input exp_t e);
        bit resp = p_valid && (cyc == p_due);
        last_ig = e.if_gnt;
        last_dg = e.d_gnt;
        if (reset) begin
            p_valid = 0;
            starve  = 0;
            m_pi    = 0;
            m_pd    = 0;
            return;
        end
        if (bus.if_req && !e.if_gnt && m_pi < 64'hFFFF_FFFF) m_pi++;
        if (bus.d_req && !e.d_gnt && m_pd < 64'hFFFF_FFFF) m_pd++;
        if (e.if_gnt || e.d_gnt) begin
            p_valid  = 1;
            p_due    = cyc + MEM_LAT;
            p_fetch  = e.if_gnt;
            p_store  = e.d_gnt && bus.d_we;
            p_killed = e.if_gnt && bus.if_kill;
            p_data   = mdl_rd(e.if_gnt ? bus.if_addr : bus.d_addr);
            if (p_store) mdl_mem[int'(bus.d_addr >> 2)] = merge(mdl_rd(bus.d_addr), bus.d_wdata, bus.d_wstrb);
        end else if (resp) begin
            p_valid = 0;
        end else if (p_valid && p_fetch && bus.if_kill) begin
            p_killed = 1;
        end
        if (!bus.if_req || e.if_gnt) starve = 0;
        else if (e.d_gnt && starve < STARVE_MAX) starve++;
    endtask

    task automatic ram_capture();
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1)
                ram[int'(bus.mem_addr >> 2)] = merge(ram_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
            else
                rdq.push_back('{cyc + MEM_LAT, ram_rd(bus.mem_addr)});
        end
    endtask

    // One clock cycle: present RAM data, check outputs mid-cycle, advance model, clock.
    task automatic cycle();
        exp_t e;
        rd_t  r;
        while (rdq.size() > 0 && rdq[0].due < cyc) r = rdq.pop_front();
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            r = rdq.pop_front();
            bus.mem_rdata = r.data;
        end else begin
            bus.mem_rdata = $urandom;
        end
        #4;
        model_eval(e);
        obs.if_gnt    = bus.if_gnt;
        obs.d_gnt     = bus.d_gnt;
        obs.mem_en    = bus.mem_en;
        obs.mem_we    = bus.mem_we;
        obs.mem_wstrb = bus.mem_wstrb;
        obs.mem_addr  = bus.mem_addr;
        obs.mem_wdata = bus.mem_wdata;
        obs.if_rvalid = bus.if_rvalid;
        obs.if_rdata  = bus.if_rdata;
        obs.d_rvalid  = bus.d_rvalid;
        obs.d_rdata   = bus.d_rdata;
        obs.arb_busy  = bus.arb_busy;
        check("if_gnt",    32'(obs.if_gnt),    32'(e.if_gnt));
        check("d_gnt",     32'(obs.d_gnt),     32'(e.d_gnt));
        check("mem_en",    32'(obs.mem_en),    32'(e.mem_en));
        check("mem_we",    32'(obs.mem_we),    32'(e.mem_we));
        if (e.chk_wstrb) check("mem_wstrb", 32'(obs.mem_wstrb), 32'(e.mem_wstrb));
        if (e.chk_addr)  check("mem_addr",  obs.mem_addr,  e.mem_addr);
        if (e.chk_wdata) check("mem_wdata", obs.mem_wdata, e.mem_wdata);
        check("if_rvalid", 32'(obs.if_rvalid), 32'(e.if_rvalid));
        check("if_rdata",  obs.if_rdata,       e.if_rdata);
        check("d_rvalid",  32'(obs.d_rvalid),  32'(e.d_rvalid));
        check("d_rdata",   obs.d_rdata,        e.d_rdata);
        check("arb_busy",  32'(obs.arb_busy),  32'(e.arb_busy));
`ifdef ARB_PERF_CNT_EN
        if (!reset) begin
            check("perf_if_wait", perf_if_wait, 32'(m_pi));
            check("perf_d_wait",  perf_d_wait,  32'(m_pd));
        end
`endif
        model_commit(e);
        ram_capture();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet(input int n);
        bus.if_req  = 0;
        bus.d_req   = 0;
        bus.if_kill = 0;
        bus.d_we    = 0;
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.mem_rdata = 0;
        mdl_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        ram[32'h100 >> 2]     = 32'hDEAD_BEEF;

        cycle();
        cycle();
        check("reset_busy", 32'(obs.arb_busy), 32'd0);
        reset = 1'b0;
        quiet(1);

        // Single load.
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        cycle();
        check("load_gnt", 32'(obs.d_gnt), 32'd1);
        check("load_en",  32'(obs.mem_en), 32'd1);
        bus.d_req = 0;
        cycle();
        check("load_busy1", 32'(obs.arb_busy), 32'd1);
        cycle();
        check("load_rvalid", 32'(obs.d_rvalid), 32'd1);
        check("load_rdata",  obs.d_rdata, 32'hDEAD_BEEF);
        check("load_busy2",  32'(obs.arb_busy), 32'd1);
        quiet(2);

        // Collision: data first, fetch back-to-back in the response cycle.
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.d_req = 1; bus.d_addr = 32'h24;
        cycle();
        check("coll_d_gnt", 32'(obs.d_gnt), 32'd1);
        check("coll_if_gnt0", 32'(obs.if_gnt), 32'd0);
        bus.d_req = 0;
        cycle();
        cycle();
        check("coll_if_gnt2", 32'(obs.if_gnt), 32'd1);
        bus.if_req = 0;
        cycle();
        cycle();
        check("coll_if_rvalid", 32'(obs.if_rvalid), 32'd1);
        quiet(3);

        // Starvation: four data slots, then a forced fetch, then data again.
        bus.if_req = 1; bus.if_addr = 32'h30;
        bus.d_req = 1; bus.d_addr = 32'h34;
        for (int slot = 0; slot < 6; slot++) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                cycle();
                if (k == 0) begin
                    check("starve_d_gnt",  32'(obs.d_gnt),  (slot == 4) ? 32'd0 : 32'd1);
                    check("starve_if_gnt", 32'(obs.if_gnt), (slot == 4) ? 32'd1 : 32'd0);
                end
            end
        end
        quiet(3);

        // Kill after grant suppresses the fetch response; port is still reusable.
        bus.if_req = 1; bus.if_addr = 32'h40;
        cycle();
        check("kill_if_gnt", 32'(obs.if_gnt), 32'd1);
        bus.if_req = 0; bus.if_kill = 1;
        cycle();
        bus.if_kill = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
        cycle();
        check("kill_no_rvalid", 32'(obs.if_rvalid), 32'd0);
        check("kill_d_gnt", 32'(obs.d_gnt), 32'd1);
        bus.d_req = 0;
        cycle();
        cycle();
        check("kill_d_rvalid", 32'(obs.d_rvalid), 32'd1);
        quiet(2);

        // Store with partial strobes completes with zero read data.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h50; bus.d_wdata = 32'h1234; bus.d_wstrb = 4'b0011;
        cycle();
        check("st_we",    32'(obs.mem_we), 32'd1);
        check("st_wstrb", 32'(obs.mem_wstrb), 32'h3);
        check("st_wdata", obs.mem_wdata, 32'h1234);
        bus.d_req = 0; bus.d_we = 0;
        cycle();
        cycle();
        check("st_rvalid", 32'(obs.d_rvalid), 32'd1);
        check("st_rdata",  obs.d_rdata, 32'h0);
        bus.d_req = 1; bus.d_addr = 32'h50;
        cycle();
        bus.d_req = 0;
        quiet(3);

        // Reset mid-transaction drops the outstanding fetch.
        bus.if_req = 1; bus.if_addr = 32'h60;
        cycle();
        bus.if_req = 0; reset = 1;
        cycle();
        reset = 0;
        cycle();
        check("rst_busy",   32'(obs.arb_busy), 32'd0);
        check("rst_rvalid", 32'(obs.if_rvalid), 32'd0);
        check("rst_mem_en", 32'(obs.mem_en), 32'd0);
        repeat (2) begin
            cycle();
            check("rst_no_rvalid", 32'(obs.if_rvalid), 32'd0);
        end
        bus.if_req = 1; reset = 1;
        cycle();
        check("rst_held_gnt", 32'(obs.if_gnt), 32'd0);
        reset = 0;
        cycle();
        check("rst_first_gnt", 32'(obs.if_gnt), 32'd1);
        quiet(3);

        // Random traffic with withdrawals, kills and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!(bus.if_req && !last_ig && $urandom_range(0, 9) != 0)) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = rand_addr();
            end
            if (!(bus.d_req && !last_dg && $urandom_range(0, 9) != 0)) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom;
                bus.d_wstrb = 4'($urandom_range(0, 15));
            end
            bus.if_kill = ($urandom_range(0, 7) == 0);
            cycle();
        end
        reset = 0;
        quiet(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency RAM between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between fetch_stage / data-memory access logic and the physical memory macro.
- Allows one outstanding transaction at a time. Data requests have priority, bounded by a fetch-starvation limit.
- Fetch responses can be cancelled by a pipeline redirect.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width (byte strobes = DATA_W/8)
MEM_LAT, 2, cycles from issue to read data valid on mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive data grants won against a waiting fetch before fetch is forced to win; legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_kill  in  1  redirect/flush; cancels any outstanding fetch response
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid / store complete
d_rdata  out  DATA_W  load data; 0 for store completions
mem_en  out  1  memory access issue strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue
arb_busy  out  1  transaction outstanding (count != 0)

Behaviour:
- Latency counter `cnt`:
  - Loaded with MEM_LAT on the issue edge, decrements each cycle.
  - The response cycle is the cycle in which cnt == 1.
- Issue eligibility:
  - Issue is allowed when cnt <= 1, so back-to-back issue is possible in the response cycle.
  - Throughput is one access per MEM_LAT cycles.
- Grant and issue timing:
  - Grant is combinational in an eligible cycle: gnt, mem_en and mem_* are driven in the same cycle as the winning req.
  - When not issuing: mem_en = 0, mem_we = 0, mem_wstrb = 0.
  - A fetch issue always drives mem_we = 0 and mem_wstrb = 0.
- Arbitration:
  - Only one request: it wins.
  - Both requests: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt (4 bits):
  - Increments on a data grant while if_req = 1.
  - Clears on a fetch grant, or in any cycle where if_req = 0.
  - Saturates at STARVE_MAX.
- Owner register: records fetch or data for the outstanding transaction, plus a `killed` flag.
- Response cycle, data owner:
  - d_rvalid = 1.
  - d_rdata = mem_rdata for loads, 0 for stores.
- Response cycle, fetch owner:
  - if_rvalid = 1 and if_rdata = mem_rdata, unless killed or if_kill is asserted this cycle.
  - A suppressed response still frees the port.
- if_kill:
  - Sets `killed` if a fetch transaction is outstanding, including one granted in the same cycle.
  - Has no effect on data transactions or on idle state.
- Outside the response cycle, rvalid = 0 and rdata = 0.
- Requester obligations:
  - Request signals must be held stable until gnt; changes before gnt are not errors.
  - Dropping req before gnt withdraws the request with no side effects.
- Reset mid-transaction:
  - cnt, starve_cnt, owner and killed clear to 0.
  - The outstanding response is dropped; no rvalid appears after reset deasserts.
- Reset values: every output is 0.

Optional Feature:
ARB_PERF_CNT_EN
- Defined:
  - Adds outputs perf_if_wait [31:0] and perf_d_wait [31:0].
  - Each counts cycles its req = 1 and gnt = 0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single load, MEM_LAT = 2: d_req = 1, d_addr = 0x100 at cycle 0, mem_rdata = 0xDEADBEEF at cycle 2 -> d_gnt = 1 and mem_en = 1 at cycle 0; d_rvalid = 1 with d_rdata = 0xDEADBEEF at cycle 2; arb_busy = 1 at cycles 1-2.
- Collision: if_req and d_req both held from cycle 0 -> data granted at cycle 0; fetch granted at cycle 2 (back-to-back issue); if_rvalid at cycle 4.
- Starvation, STARVE_MAX = 4: if_req held and d_req held continuously -> data granted 4 times, fetch granted on the 5th slot, then starve_cnt = 0 and data wins again.
- Kill: fetch granted at cycle 0, if_kill pulsed at cycle 1 -> no if_rvalid at cycle 2; a data request granted at cycle 2 gets d_rvalid at cycle 4.
- Store: d_we = 1, d_wstrb = 4'b0011, d_wdata = 0x1234 -> mem_we = 1, mem_wstrb = 4'b0011 in the grant cycle; d_rvalid = 1 with d_rdata = 0 after MEM_LAT cycles.
- Reset mid-transaction: fetch granted at cycle 0, reset = 1 at cycle 1 -> all outputs 0 at cycle 2; no if_rvalid thereafter; a new grant is possible in the first cycle after reset deasserts.
